// File: rtl/n64adv_ppu_outstage.sv
// n64adv_ppu_outstage: final PPU video output stage in the VCLK domain.
// Aligns colour and sync via a tapped delay line, builds both CSYNC outputs,
// routes either VGA H/V sync or filter-select onto the shared pins, and mutes
// everything for a fixed window after a line-multiplier mode change.
module n64adv_ppu_outstage #(
    parameter int COLOR_W     = 8,
    parameter int DELAY_DEPTH = 4,
    parameter int TAP_W       = 3,
    parameter int MODE_W      = 2,
    parameter int HOLD_CYCLES = 15
) (
    input  logic                   VCLK,
    input  logic                   nRST,
    input  logic [4+3*COLOR_W-1:0] vdata_i,
    input  logic [MODE_W-1:0]      cfg_mode,
    input  logic [TAP_W-1:0]       cfg_tap,
    input  logic                   cfg_nEN_YPbPr,
    input  logic                   cfg_nEN_RGsB,
    input  logic [2:0]             cfg_filter,
    input  logic                   UseVGA_HVSync,
    output logic [3*COLOR_W-1:0]   VD_o,
    output logic [1:0]             nCSYNC,
    output logic                   nVSYNC_or_F2,
    output logic                   nHSYNC_or_F1,
    output logic [1:0]             filter_o,
    output logic                   mute_o
);

    localparam int VW    = 4 + 3*COLOR_W;
    localparam int CW    = 3*COLOR_W;
    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    // Sync field positions inside a video word {nVS,nBLANK,nHS,nCS,R,G,B}
    localparam int NVS_BIT    = VW - 1;
    localparam int NBLANK_BIT = VW - 2;
    localparam int NHS_BIT    = VW - 3;
    localparam int NCS_BIT    = VW - 4;

    logic [MODE_W-1:0] b0, b1, b2;
    logic [CNT_W-1:0]  cnt;
    logic [VW-1:0]     d [DELAY_DEPTH];
    logic [VW-1:0]     src;
    logic [31:0]       tap_u;
    logic [31:0]       b2_u;
    logic [1:0]        filter_nxt;
    logic              mode_chg;
    logic              mute_nxt;
    logic              blank_unused;

    assign tap_u        = 32'(cfg_tap);
    assign b2_u         = 32'(b2);
    assign blank_unused = src[NBLANK_BIT];

    // A change is seen when the values b1/b2 take at this edge differ, i.e. b0 vs b1 now.
    assign mode_chg = (b0 != b1);
    assign mute_nxt = mode_chg || (cnt != '0);

    // Tap select: taps beyond the line depth clamp to the deepest stage.
    always_comb begin
        src = vdata_i;
        for (int k = 1; k <= DELAY_DEPTH; k++) begin
            if ((tap_u == 32'(k)) || ((k == DELAY_DEPTH) && (tap_u > 32'(DELAY_DEPTH))))
                src = d[k-1];
        end
    end

    // Filter code: auto follows the settled mode (saturated), manual is code minus one.
    always_comb begin
        filter_nxt = 2'b00;
        if (cfg_filter == 3'd0)
            filter_nxt = (b2_u > 32'd3) ? 2'b11 : b2_u[1:0];
        else
            filter_nxt = cfg_filter[1:0] - 2'd1;
    end

    // Mode history and hold counter; a fresh change always restarts the hold.
    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            b0     <= cfg_mode;
            b1     <= cfg_mode;
            b2     <= cfg_mode;
            cnt    <= '0;
            mute_o <= 1'b0;
        end else begin
            b0 <= cfg_mode;
            b1 <= b0;
            b2 <= b1;
            if (mode_chg) begin
                cnt    <= CNT_W'(HOLD_CYCLES);
                mute_o <= 1'b1;
            end else if (cnt != '0) begin
                cnt    <= cnt - CNT_W'(1);
                mute_o <= 1'b1;
            end else begin
                mute_o <= 1'b0;
            end
        end
    end

    // Delay line, flushed while muted so no stale video leaks out after unmute.
    always_ff @(posedge VCLK) begin
        if (!nRST || mute_nxt) begin
            for (int k = 0; k < DELAY_DEPTH; k++)
                d[k] <= '0;
        end else begin
            d[0] <= vdata_i;
            for (int k = 1; k < DELAY_DEPTH; k++)
                d[k] <= d[k-1];
        end
    end

    // Output registers: colour, CSYNC pair, shared sync/filter pins and filter code.
    always_ff @(posedge VCLK) begin
        if (!nRST || mute_nxt) begin
            VD_o         <= '0;
            nCSYNC       <= 2'b00;
            nVSYNC_or_F2 <= 1'b0;
            nHSYNC_or_F1 <= 1'b0;
            filter_o     <= 2'b00;
        end else begin
            VD_o      <= src[CW-1:0];
            nCSYNC[1] <= src[NCS_BIT];
            nCSYNC[0] <= (cfg_nEN_RGsB & cfg_nEN_YPbPr) ? 1'b0 : src[NCS_BIT];
            filter_o  <= filter_nxt;
            if (UseVGA_HVSync) begin
                nVSYNC_or_F2 <= src[NVS_BIT];
                nHSYNC_or_F1 <= src[NHS_BIT];
            end else begin
                nVSYNC_or_F2 <= filter_o[0];
                nHSYNC_or_F1 <= filter_o[1];
            end
        end
    end

endmodule

// File: tb/tb_n64adv_ppu_outstage.sv
// tb_n64adv_ppu_outstage: directed scoreboard bench for the PPU output stage.
module tb_n64adv_ppu_outstage;

    logic        VCLK = 1'b0;
    logic        nRST;
    logic [27:0] vdata_i;
    logic [1:0]  cfg_mode;
    logic [2:0]  cfg_tap;
    logic        cfg_nEN_YPbPr;
    logic        cfg_nEN_RGsB;
    logic [2:0]  cfg_filter;
    logic        UseVGA_HVSync;
    logic [23:0] VD_o;
    logic [1:0]  nCSYNC;
    logic        nVSYNC_or_F2;
    logic        nHSYNC_or_F1;
    logic [1:0]  filter_o;
    logic        mute_o;

    typedef struct {
        string       tag;
        logic [30:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [27:0] V0 = {4'b1111, 24'h000000};
    localparam logic [27:0] V1 = {4'b1111, 24'h123456};
    localparam logic [27:0] VP = {4'b1110, 24'hFF8001};

    n64adv_ppu_outstage dut (
        .VCLK          (VCLK),
        .nRST          (nRST),
        .vdata_i       (vdata_i),
        .cfg_mode      (cfg_mode),
        .cfg_tap       (cfg_tap),
        .cfg_nEN_YPbPr (cfg_nEN_YPbPr),
        .cfg_nEN_RGsB  (cfg_nEN_RGsB),
        .cfg_filter    (cfg_filter),
        .UseVGA_HVSync (UseVGA_HVSync),
        .VD_o          (VD_o),
        .nCSYNC        (nCSYNC),
        .nVSYNC_or_F2  (nVSYNC_or_F2),
        .nHSYNC_or_F1  (nHSYNC_or_F1),
        .filter_o      (filter_o),
        .mute_o        (mute_o)
    );

    // Free-running output clock
    always #5 VCLK = ~VCLK;

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [30:0] pk(input logic [23:0] vd, input logic [1:0] cs,
                                       input logic nv, input logic nh,
                                       input logic [1:0] f, input logic m);
        return {vd, cs, nv, nh, f, m};
    endfunction

    task automatic pushExpect(input string tag, input logic [30:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input logic [27:0] vd, input logic [1:0] mode, input logic [2:0] tap);
        vdata_i  = vd;
        cfg_mode = mode;
        cfg_tap  = tap;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [30:0] obs;
        @(posedge VCLK);
        #1;
        obs = {VD_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1, filter_o, mute_o};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty: observed %h required nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        // Reset with all-ones video; mode 1 is loaded into the mode history
        nRST          = 1'b0;
        cfg_nEN_YPbPr = 1'b1;
        cfg_nEN_RGsB  = 1'b1;
        cfg_filter    = 3'd0;
        UseVGA_HVSync = 1'b1;
        applyStimulus(28'hFFFFFFF, 2'd1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            pushExpect("reset_zero", '0);
            checkOutput();
        end

        // Release: tap 0 passes idle video, auto filter = mode 1, no mute pulse
        nRST = 1'b1;
        applyStimulus(V0, 2'd1, 3'd0);
        for (int i = 0; i < 4; i++) begin
            pushExpect("post_reset_nomute", pk(24'h0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0));
            checkOutput();
        end

        // Tap 2: single-cycle pulse appears on the third edge after it is driven
        applyStimulus(V0, 2'd1, 3'd2);
        pushExpect("tap2_idle", pk(24'h0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0));
        checkOutput();
        applyStimulus(VP, 2'd1, 3'd2);
        for (int k = 1; k <= 5; k++)
            pushExpect("tap2_latency", (k == 3) ? pk(24'hFF8001, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0)
                                                : pk(24'h0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0));
        checkOutput();
        applyStimulus(V0, 2'd1, 3'd2);
        for (int k = 2; k <= 5; k++) checkOutput();

        // Tap 7 clamps to tap 4: pulse appears on the fifth edge
        applyStimulus(VP, 2'd1, 3'd7);
        for (int k = 1; k <= 6; k++)
            pushExpect("tap7_clamp", (k == 5) ? pk(24'hFF8001, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0)
                                              : pk(24'h0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0));
        checkOutput();
        applyStimulus(V0, 2'd1, 3'd7);
        for (int k = 2; k <= 6; k++) checkOutput();

        // Sync-on-green path follows nCS once RGsB is enabled
        cfg_nEN_RGsB = 1'b0;
        applyStimulus(V0, 2'd1, 3'd0);
        pushExpect("rgsb_cs_high", pk(24'h0, 2'b11, 1'b1, 1'b1, 2'b01, 1'b0));
        checkOutput();
        applyStimulus({4'b1110, 24'h0}, 2'd1, 3'd0);
        pushExpect("rgsb_cs_low", pk(24'h0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0));
        checkOutput();
        cfg_nEN_RGsB  = 1'b1;
        cfg_nEN_YPbPr = 1'b0;
        applyStimulus(V0, 2'd1, 3'd0);
        pushExpect("ypbpr_cs_high", pk(24'h0, 2'b11, 1'b1, 1'b1, 2'b01, 1'b0));
        checkOutput();
        cfg_nEN_YPbPr = 1'b1;
        cfg_nEN_RGsB  = 1'b0;

        // Manual filter on the shared pins, pins lag filter_o by one cycle
        UseVGA_HVSync = 1'b0;
        cfg_filter    = 3'd3;
        pushExpect("filter_pins_lag", pk(24'h0, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0));
        checkOutput();
        pushExpect("filter_pins", pk(24'h0, 2'b11, 1'b0, 1'b1, 2'b10, 1'b0));
        checkOutput();

        // VGA mode: pins carry nVS/nHS from the video word
        UseVGA_HVSync = 1'b1;
        applyStimulus({4'b1101, 24'h0}, 2'd1, 3'd0);
        pushExpect("vga_hs_low", pk(24'h0, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0));
        checkOutput();
        applyStimulus({4'b0111, 24'h0}, 2'd1, 3'd0);
        pushExpect("vga_vs_low", pk(24'h0, 2'b11, 1'b0, 1'b1, 2'b10, 1'b0));
        checkOutput();
        cfg_filter = 3'd0;

        // Second reset with mode 0 loaded
        nRST = 1'b0;
        applyStimulus(V0, 2'd0, 3'd0);
        for (int i = 0; i < 2; i++) begin
            pushExpect("reset2_zero", '0);
            checkOutput();
        end
        nRST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pushExpect("reset2_release", pk(24'h0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0));
            checkOutput();
        end

        // Mode 0->1, then 1->2 during the hold: mute restarts, stale video flushed
        applyStimulus(V1, 2'd1, 3'd2);
        for (int e = 1; e <= 24; e++) begin
            if (e == 1)
                pushExpect("mode_first_edge", pk(24'h0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0));
            else if (e <= 21)
                pushExpect("mode_mute", pk(24'h0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1));
            else if (e <= 23)
                pushExpect("mode_unmute_flushed", pk(24'h0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0));
            else
                pushExpect("mode_unmute_video", pk(24'h0, 2'b11, 1'b1, 1'b1, 2'b10, 1'b0));
            checkOutput();
            if (e == 4)  cfg_mode = 2'd2;
            if (e == 21) vdata_i  = V0;
        end

        // Mode 2->3, then reset part-way through the hold (counter at 7)
        cfg_mode = 2'd3;
        for (int m = 1; m <= 10; m++) begin
            if (m == 1)
                pushExpect("hold2_first_edge", pk(24'h0, 2'b11, 1'b1, 1'b1, 2'b10, 1'b0));
            else
                pushExpect("hold2_mute", pk(24'h0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1));
            checkOutput();
        end
        nRST = 1'b0;
        pushExpect("midhold_reset", '0);
        checkOutput();
        nRST = 1'b1;
        for (int m = 12; m <= 15; m++) begin
            if (m <= 13)
                pushExpect("after_midhold_nomute", pk(24'h0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0));
            else
                pushExpect("after_midhold_video", pk(24'h0, 2'b11, 1'b1, 1'b1, 2'b11, 1'b0));
            checkOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
